// File: rtl/pll_reconfig_pkg.sv
// Shared types and constants for the PLL scan-chain reconfiguration controller.
package pll_reconfig_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    UPDATE,
    WAIT_DONE,
    RESET_PLL,
    WAIT_LOCK
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_DONE_TMO = 2'd1;
  localparam logic [1:0] ERR_LOCK_TMO = 2'd2;

  localparam int unsigned DEFAULT_SCAN_LEN = 144;

endpackage

// File: rtl/pll_sync2.sv
// Two-flop synchronizer with asynchronous active-low reset.
module pll_sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_reconfig_ctrl.sv
// Shifts a scan-chain image into an altpll, then runs configupdate, scandone,
// areset and lock handshakes with timeouts.
module pll_reconfig_ctrl
  import pll_reconfig_pkg::*;
#(
  parameter int unsigned SCAN_LEN     = DEFAULT_SCAN_LEN,
  parameter int unsigned DONE_TIMEOUT = 1024,
  parameter int unsigned RESET_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT = 65536
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [SCAN_LEN-1:0] cfg_data,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [1:0]          err_code,
  output logic                pll_scanclk,
  output logic                pll_scanclkena,
  output logic                pll_scandata,
  output logic                pll_configupdate,
  output logic                pll_areset,
  input  logic                pll_scandone,
  input  logic                pll_locked
);

  localparam int unsigned TMO_MAX = (DONE_TIMEOUT > LOCK_TIMEOUT) ? DONE_TIMEOUT : LOCK_TIMEOUT;
  localparam int unsigned TMO_W   = $clog2(TMO_MAX + 1);
  localparam int unsigned CNT_W   = $clog2(SCAN_LEN + 1);

  state_t              r_state;
  state_t              w_next;
  logic [SCAN_LEN-1:0] r_shift;
  logic [CNT_W-1:0]    r_bit_cnt;
  logic [TMO_W-1:0]    r_tmo_cnt;
  logic                w_scandone;
  logic                w_locked;
  logic [1:0]          w_fault;
  logic                w_busy;
  logic                w_ena;
  logic                w_upd;
  logic                w_ars;
  logic                w_done;
  logic                w_sclk;

  pll_sync2 #(.WIDTH(1)) u_sync_done (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (pll_scandone),
    .o_q   (w_scandone)
  );

  pll_sync2 #(.WIDTH(1)) u_sync_lock (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (pll_locked),
    .o_q   (w_locked)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Awaited signal is tested before the timeout so success wins a tie.
  always_comb begin
    w_next  = r_state;
    w_fault = ERR_NONE;
    unique case (r_state)
      IDLE:      if (start) w_next = SHIFT;
      SHIFT:     if (pll_scanclk && r_bit_cnt == CNT_W'(SCAN_LEN - 1)) w_next = UPDATE;
      UPDATE:    if (r_tmo_cnt == TMO_W'(1)) w_next = WAIT_DONE;
      WAIT_DONE: begin
        if (w_scandone) w_next = RESET_PLL;
        else if (r_tmo_cnt >= TMO_W'(DONE_TIMEOUT - 1)) begin
          w_next  = IDLE;
          w_fault = ERR_DONE_TMO;
        end
      end
      RESET_PLL: if (r_tmo_cnt == TMO_W'(RESET_CYCLES - 1)) w_next = WAIT_LOCK;
      WAIT_LOCK: begin
        if (w_locked) w_next = IDLE;
        else if (r_tmo_cnt >= TMO_W'(LOCK_TIMEOUT - 1)) begin
          w_next  = IDLE;
          w_fault = ERR_LOCK_TMO;
        end
      end
      default:   w_next = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up with the state.
  always_comb begin
    w_busy = (w_next != IDLE);
    w_ena  = (w_next == SHIFT);
    w_upd  = (w_next == UPDATE);
    w_ars  = (w_next == RESET_PLL);
    w_done = (r_state == WAIT_LOCK) && w_locked;
    w_sclk = (r_state == SHIFT && w_next == SHIFT) ? ~pll_scanclk : 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy             <= 1'b0;
      done             <= 1'b0;
      error            <= 1'b0;
      err_code         <= ERR_NONE;
      pll_scanclk      <= 1'b0;
      pll_scanclkena   <= 1'b0;
      pll_configupdate <= 1'b0;
      pll_areset       <= 1'b0;
      r_shift          <= '0;
      r_bit_cnt        <= '0;
      r_tmo_cnt        <= '0;
    end else begin
      busy             <= w_busy;
      done             <= w_done;
      pll_scanclk      <= w_sclk;
      pll_scanclkena   <= w_ena;
      pll_configupdate <= w_upd;
      pll_areset       <= w_ars;

      if (r_state == IDLE && start) begin
        r_shift   <= cfg_data;
        r_bit_cnt <= '0;
        error     <= 1'b0;
        err_code  <= ERR_NONE;
      end else if (r_state == SHIFT && pll_scanclk) begin
        r_shift   <= {r_shift[SCAN_LEN-2:0], 1'b0};
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end

      if (w_fault != ERR_NONE) begin
        error    <= 1'b1;
        err_code <= w_fault;
      end

      if (w_next != r_state)    r_tmo_cnt <= '0;
      else if (r_tmo_cnt != '1) r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  assign pll_scandata = r_shift[SCAN_LEN-1];

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Directed bench for pll_reconfig_ctrl with SCAN_LEN=8 and a behavioural PLL model.
module tb_pll_reconfig_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] cfg_data = '0;
  logic       busy, done, error;
  logic [1:0] err_code;
  logic       pll_scanclk, pll_scanclkena, pll_scandata;
  logic       pll_configupdate, pll_areset;
  logic       m_scandone = 1'b0;
  logic       m_locked = 1'b0;

  logic sd_en = 1'b1;
  logic lk_en = 1'b1;
  int   sd_cnt = -1;
  int   lk_cnt = -1;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] cap;
  int cap_n, ena_cyc, upd_cyc, ars_cyc, done_cnt, post_upd, post_ars;
  int first_busy, first_err, done_busy_ok;

  pll_reconfig_ctrl #(
    .SCAN_LEN     (8),
    .DONE_TIMEOUT (32),
    .RESET_CYCLES (16),
    .LOCK_TIMEOUT (100)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .cfg_data         (cfg_data),
    .busy             (busy),
    .done             (done),
    .error            (error),
    .err_code         (err_code),
    .pll_scanclk      (pll_scanclk),
    .pll_scanclkena   (pll_scanclkena),
    .pll_scandata     (pll_scandata),
    .pll_configupdate (pll_configupdate),
    .pll_areset       (pll_areset),
    .pll_scandone     (m_scandone),
    .pll_locked       (m_locked)
  );

  always #5 clk = ~clk;

  // PLL model: scandone 10 cycles after configupdate, locked 50 cycles after areset falls.
  always @(posedge clk) begin
    if (pll_configupdate)    sd_cnt <= 0;
    else if (pll_scanclkena) sd_cnt <= -1;
    else if (sd_cnt >= 0 && sd_cnt < 10) sd_cnt <= sd_cnt + 1;
    if (pll_scanclkena) m_scandone <= 1'b0;
    else if (!pll_configupdate && sd_cnt == 10 && sd_en) m_scandone <= 1'b1;

    if (pll_areset) begin
      lk_cnt   <= 0;
      m_locked <= 1'b0;
    end else if (lk_cnt >= 0 && lk_cnt < 50) lk_cnt <= lk_cnt + 1;
    else if (lk_cnt == 50 && lk_en) m_locked <= 1'b1;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic start_cfg(input logic [7:0] data);
    @(negedge clk);
    cfg_data = data;
    start    = 1'b1;
  endtask

  // Samples on negedges until busy drops; optionally pulses start again at cycle inj_at.
  task automatic run(input int budget, input int inj_at);
    logic prev_sclk, seen_upd, seen_ars, finished;
    cap = '0; cap_n = 0; ena_cyc = 0; upd_cyc = 0; ars_cyc = 0; done_cnt = 0;
    post_upd = 0; post_ars = 0; first_busy = 0; first_err = 1; done_busy_ok = 0;
    prev_sclk = 1'b0; seen_upd = 1'b0; seen_ars = 1'b0; finished = 1'b0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        first_busy = int'(busy);
        first_err  = int'(error);
      end
      if (pll_scanclk && !prev_sclk) begin
        cap = {cap[6:0], pll_scandata};
        cap_n++;
      end
      prev_sclk = pll_scanclk;
      ena_cyc += int'(pll_scanclkena);
      upd_cyc += int'(pll_configupdate);
      ars_cyc += int'(pll_areset);
      done_cnt += int'(done);
      if (pll_configupdate) seen_upd = 1'b1;
      if (pll_areset) seen_ars = 1'b1;
      if (busy && seen_upd && !pll_configupdate && !seen_ars) post_upd++;
      if (busy && seen_ars && !pll_areset) post_ars++;
      if (done && !busy) done_busy_ok = 1;
      start = (cyc == inj_at);
      if (cyc == inj_at) cfg_data = 8'hFF;
      if (!busy) begin
        finished = 1'b1;
        break;
      end
    end
    start = 1'b0;
    if (!finished) check("run_timeout", 0, 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_outputs",
          int'({busy, done, error, err_code, pll_scanclk, pll_scanclkena,
                pll_scandata, pll_configupdate, pll_areset}), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Shift order and nominal completion
    start_cfg(8'hA5);
    run(400, -1);
    check("busy_rise", first_busy, 1);
    check("scan_bits", int'(cap), 8'hA5);
    check("scan_rises", cap_n, 8);
    check("scanclkena_cycles", ena_cyc, 16);
    check("configupdate_cycles", upd_cyc, 2);
    check("areset_cycles", ars_cyc, 16);
    check("done_pulses", done_cnt, 1);
    check("done_with_busy_fall", done_busy_ok, 1);
    check("nominal_error", int'(error), 0);
    check("nominal_err_code", int'(err_code), 0);

    // Start while busy is ignored
    repeat (2) @(negedge clk);
    start_cfg(8'hA5);
    run(400, 5);
    check("busy_start_bits", int'(cap), 8'hA5);
    check("busy_start_done", done_cnt, 1);
    repeat (4) @(negedge clk);
    check("busy_start_not_queued", int'(busy), 0);

    // Scandone timeout
    sd_en = 1'b0;
    start_cfg(8'h5A);
    run(400, -1);
    check("done_tmo_error", int'(error), 1);
    check("done_tmo_code", int'(err_code), 1);
    check("done_tmo_window", int'(post_upd >= 30 && post_upd <= 34), 1);
    check("done_tmo_no_areset", ars_cyc, 0);

    // Lock timeout
    sd_en = 1'b1;
    lk_en = 1'b0;
    start_cfg(8'h81);
    run(400, -1);
    check("first_err_cleared", first_err, 0);
    check("lock_tmo_error", int'(error), 1);
    check("lock_tmo_code", int'(err_code), 2);
    check("lock_tmo_window", int'(post_ars >= 98 && post_ars <= 102), 1);
    check("lock_tmo_no_done", done_cnt, 0);

    // Recovery
    lk_en = 1'b1;
    start_cfg(8'h3C);
    run(400, -1);
    check("recover_err_cleared", first_err, 0);
    check("recover_bits", int'(cap), 8'h3C);
    check("recover_done", done_cnt, 1);
    check("recover_code", int'(err_code), 0);

    // Reset mid-SHIFT, after 3 scanclk rising edges
    start_cfg(8'hA5);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_shift_ena", int'(pll_scanclkena), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs",
          int'({busy, done, error, err_code, pll_scanclk, pll_scanclkena,
                pll_scandata, pll_configupdate, pll_areset}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_cfg(8'hA5);
    run(400, -1);
    check("post_reset_bits", int'(cap), 8'hA5);
    check("post_reset_rises", cap_n, 8);
    check("post_reset_done", done_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
